// File: rtl/ctrl_unit_pipe.sv
// Decode, hazard, branch-resolve and forwarding control for a 5-stage RV32I pipe.
// Latency: decode/hazard comb in ID; control word reaches EX +1, MEM +2, WB +3 cycles.
// Backpressure: o_stall holds PC and IF/ID and inserts an EX bubble; o_flush kills ID.
module ctrl_unit_pipe #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instr,
  input  logic             i_id_vld,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_pc_sel,
  output logic             o_illegal,
  output logic             o_ex_br_un,
  output logic [1:0]       o_ex_opa_sel,
  output logic             o_ex_opb_sel,
  output logic [3:0]       o_ex_alu_op,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic             o_mem_wren,
  output logic             o_wb_rd_wren,
  output logic [1:0]       o_wb_sel,
  output logic [4:0]       o_wb_rd_addr,
  output logic             o_wb_insn_vld,
  output logic [CNT_W-1:0] o_retire_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // Control word carried down the pipe; an all-zero word is a bubble.
  typedef struct packed {
    logic       vld;
    logic       rd_wren;
    logic       mem_wren;
    logic       is_br;
    logic       is_jmp;
    logic       is_load;
    logic       br_un;
    logic [1:0] opa_sel;
    logic       opb_sel;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  ctrl_t            id_cw;
  ctrl_t            ex_d, ex_q;
  ctrl_t            mem_d, mem_q;
  ctrl_t            wb_d, wb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic       use_rs1, use_rs2, legal;
  logic [2:0] f3;
  logic       dep_ex, dep_mem, hazard, br_taken;

  assign f3 = i_instr[14:12];

  // Decode the IF/ID instruction into a control word plus its source-register uses.
  always_comb begin
    id_cw   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    legal   = 1'b1;
    unique case (i_instr[6:0])
      OP_R: begin
        id_cw.alu_op  = {i_instr[30], f3};
        id_cw.rd_wren = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_I: begin
        // Only the shift-right group uses bit 30 (srli/srai); elsewhere it is immediate.
        id_cw.alu_op  = {(f3 == 3'b101) & i_instr[30], f3};
        id_cw.opb_sel = 1'b1;
        id_cw.rd_wren = 1'b1;
        use_rs1       = 1'b1;
      end
      OP_LOAD: begin
        id_cw.opb_sel = 1'b1;
        id_cw.wb_sel  = 2'b01;
        id_cw.rd_wren = 1'b1;
        id_cw.is_load = 1'b1;
        use_rs1       = 1'b1;
      end
      OP_STORE: begin
        id_cw.opb_sel  = 1'b1;
        id_cw.mem_wren = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OP_BR: begin
        id_cw.opa_sel = 2'b01;
        id_cw.opb_sel = 1'b1;
        id_cw.br_un   = f3[1];
        id_cw.is_br   = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_LUI: begin
        id_cw.opa_sel = 2'b10;
        id_cw.opb_sel = 1'b1;
        id_cw.rd_wren = 1'b1;
      end
      OP_AUIPC: begin
        id_cw.opa_sel = 2'b01;
        id_cw.opb_sel = 1'b1;
        id_cw.rd_wren = 1'b1;
      end
      OP_JAL: begin
        // ALU computes the target pc+imm; link value comes from pc_four.
        id_cw.opa_sel = 2'b01;
        id_cw.opb_sel = 1'b1;
        id_cw.wb_sel  = 2'b10;
        id_cw.is_jmp  = 1'b1;
        id_cw.rd_wren = 1'b1;
      end
      OP_JALR: begin
        id_cw.opb_sel = 1'b1;
        id_cw.wb_sel  = 2'b10;
        id_cw.is_jmp  = 1'b1;
        id_cw.rd_wren = 1'b1;
        use_rs1       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    id_cw.vld    = 1'b1;
    id_cw.funct3 = f3;
    id_cw.rd     = i_instr[11:7];
    id_cw.rs1    = i_instr[19:15];
    id_cw.rs2    = i_instr[24:20];
    if (i_instr[11:7] == 5'd0) id_cw.rd_wren = 1'b0;
    if (!i_id_vld || !legal) begin
      id_cw   = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end

  assign o_illegal = i_id_vld & ~legal;

  // Hazard detection: load-use only when forwarding, any EX/MEM RAW otherwise.
  always_comb begin
    dep_ex  = (use_rs1 && id_cw.rs1 == ex_q.rd)  || (use_rs2 && id_cw.rs2 == ex_q.rd);
    dep_mem = (use_rs1 && id_cw.rs1 == mem_q.rd) || (use_rs2 && id_cw.rs2 == mem_q.rd);
    if (FWD_EN) hazard = ex_q.rd_wren & ex_q.is_load & dep_ex;
    else        hazard = (ex_q.rd_wren & dep_ex) | (mem_q.rd_wren & dep_mem);
  end

  // Branch condition from the EX comparator; reserved funct3 codes never take.
  always_comb begin
    unique case (ex_q.funct3)
      3'b000:          br_taken = i_br_equal;
      3'b001:          br_taken = ~i_br_equal;
      3'b100, 3'b110:  br_taken = i_br_less;
      3'b101, 3'b111:  br_taken = ~i_br_less;
      default:         br_taken = 1'b0;
    endcase
  end

  assign o_pc_sel = ex_q.vld & (ex_q.is_jmp | (ex_q.is_br & br_taken));
  assign o_flush  = o_pc_sel;
  // A redirect kills ID anyway, so stalling for it would only waste a cycle.
  assign o_stall  = hazard & ~o_flush;

  // Forwarding selects for the EX sources; MEM has priority as the younger producer.
  always_comb begin
    o_fwd_a_sel = 2'b00;
    o_fwd_b_sel = 2'b00;
    if (FWD_EN) begin
      if (mem_q.rd_wren && mem_q.rd == ex_q.rs1)    o_fwd_a_sel = 2'b01;
      else if (wb_q.rd_wren && wb_q.rd == ex_q.rs1) o_fwd_a_sel = 2'b10;
      if (mem_q.rd_wren && mem_q.rd == ex_q.rs2)    o_fwd_b_sel = 2'b01;
      else if (wb_q.rd_wren && wb_q.rd == ex_q.rs2) o_fwd_b_sel = 2'b10;
    end
  end

  // Next-state for the stage registers and the retire counter.
  always_comb begin
    ex_d  = (o_stall || o_flush) ? ctrl_t'('0) : id_cw;
    mem_d = ex_q;
    wb_d  = mem_q;
    // Counted on entry to WB so the count already includes the instruction shown there.
    cnt_d = cnt_q + CNT_W'(mem_q.vld);
  end

  // Stage registers and counter, all cleared to bubbles on reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_ex_br_un    = ex_q.br_un;
  assign o_ex_opa_sel  = ex_q.opa_sel;
  assign o_ex_opb_sel  = ex_q.opb_sel;
  assign o_ex_alu_op   = ex_q.alu_op;
  assign o_mem_wren    = mem_q.mem_wren;
  assign o_wb_rd_wren  = wb_q.rd_wren;
  assign o_wb_sel      = wb_q.wb_sel;
  assign o_wb_rd_addr  = wb_q.rd;
  assign o_wb_insn_vld = wb_q.vld;
  assign o_retire_cnt  = cnt_q;

  // WB-stage fields with no consumer and immediate bits this unit does not decode.
  logic unused_bits;
  assign unused_bits = ^{wb_q.mem_wren, wb_q.is_br, wb_q.is_jmp, wb_q.is_load, wb_q.br_un,
                         wb_q.opa_sel, wb_q.opb_sel, wb_q.alu_op, wb_q.funct3, wb_q.rs1,
                         wb_q.rs2, i_instr[31], i_instr[29:25]};

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
module tb_ctrl_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] instr;
  logic        id_vld, br_less, br_equal;

  // Index 0: forwarding, 1: no forwarding, 2: forwarding with 4-bit counter.
  logic [2:0] stall, flush, pc_sel, illegal, br_un, opb, memw, wbw, wbv;
  logic [1:0] opa [3];
  logic [1:0] fa [3];
  logic [1:0] fb [3];
  logic [1:0] wbsel [3];
  logic [3:0] alu [3];
  logic [4:0] wbrd [3];
  logic [31:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  ctrl_unit_pipe #(.FWD_EN(1'b1), .CNT_W(32)) dut_fwd (
    .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_id_vld(id_vld),
    .i_br_less(br_less), .i_br_equal(br_equal),
    .o_stall(stall[0]), .o_flush(flush[0]), .o_pc_sel(pc_sel[0]), .o_illegal(illegal[0]),
    .o_ex_br_un(br_un[0]), .o_ex_opa_sel(opa[0]), .o_ex_opb_sel(opb[0]), .o_ex_alu_op(alu[0]),
    .o_fwd_a_sel(fa[0]), .o_fwd_b_sel(fb[0]), .o_mem_wren(memw[0]), .o_wb_rd_wren(wbw[0]),
    .o_wb_sel(wbsel[0]), .o_wb_rd_addr(wbrd[0]), .o_wb_insn_vld(wbv[0]), .o_retire_cnt(cnt_a));

  ctrl_unit_pipe #(.FWD_EN(1'b0), .CNT_W(32)) dut_nof (
    .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_id_vld(id_vld),
    .i_br_less(br_less), .i_br_equal(br_equal),
    .o_stall(stall[1]), .o_flush(flush[1]), .o_pc_sel(pc_sel[1]), .o_illegal(illegal[1]),
    .o_ex_br_un(br_un[1]), .o_ex_opa_sel(opa[1]), .o_ex_opb_sel(opb[1]), .o_ex_alu_op(alu[1]),
    .o_fwd_a_sel(fa[1]), .o_fwd_b_sel(fb[1]), .o_mem_wren(memw[1]), .o_wb_rd_wren(wbw[1]),
    .o_wb_sel(wbsel[1]), .o_wb_rd_addr(wbrd[1]), .o_wb_insn_vld(wbv[1]), .o_retire_cnt(cnt_b));

  ctrl_unit_pipe #(.FWD_EN(1'b1), .CNT_W(4)) dut_c4 (
    .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_id_vld(id_vld),
    .i_br_less(br_less), .i_br_equal(br_equal),
    .o_stall(stall[2]), .o_flush(flush[2]), .o_pc_sel(pc_sel[2]), .o_illegal(illegal[2]),
    .o_ex_br_un(br_un[2]), .o_ex_opa_sel(opa[2]), .o_ex_opb_sel(opb[2]), .o_ex_alu_op(alu[2]),
    .o_fwd_a_sel(fa[2]), .o_fwd_b_sel(fb[2]), .o_mem_wren(memw[2]), .o_wb_rd_wren(wbw[2]),
    .o_wb_sel(wbsel[2]), .o_wb_rd_addr(wbrd[2]), .o_wb_insn_vld(wbv[2]), .o_retire_cnt(cnt_c));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: instruction words flowing through EX/MEM/WB ----
  logic [31:0] s_i [2][3];
  logic        s_v [2][3];
  logic [31:0] mcnt [2];

  function automatic logic legal(input logic [31:0] x);
    case (x[6:0])
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic writes_rd(input logic [31:0] x);
    return legal(x) && x[6:0] != 7'h23 && x[6:0] != 7'h63 && x[11:7] != 5'd0;
  endfunction
  function automatic logic use1(input logic [31:0] x);
    return x[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction
  function automatic logic use2(input logic [31:0] x);
    return x[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction
  function automatic logic [3:0] alu_of(input logic [31:0] x);
    if (x[6:0] == 7'h33) return {x[30], x[14:12]};
    if (x[6:0] == 7'h13) return {x[14:12] == 3'd5 && x[30], x[14:12]};
    return 4'd0;
  endfunction
  function automatic logic [1:0] opa_of(input logic [31:0] x);
    if (x[6:0] inside {7'h63, 7'h17, 7'h6F}) return 2'd1;
    if (x[6:0] == 7'h37) return 2'd2;
    return 2'd0;
  endfunction
  function automatic logic [1:0] wbsel_of(input logic [31:0] x);
    if (x[6:0] == 7'h03) return 2'd1;
    if (x[6:0] inside {7'h6F, 7'h67}) return 2'd2;
    return 2'd0;
  endfunction
  function automatic logic taken(input logic [2:0] f, input logic lt, input logic eq);
    case (f)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic dep(input logic [31:0] x, input logic v, input logic [4:0] rd);
    return v && legal(x) && ((use1(x) && x[19:15] == rd) || (use2(x) && x[24:20] == rd));
  endfunction

  // {stall, flush} expected for model m this cycle.
  function automatic logic [1:0] hz(input int m, input logic [31:0] x, input logic v,
                                    input logic lt, input logic eq);
    logic [31:0] e, mi;
    logic ev, mv, fl, h;
    e = s_i[m][0]; ev = s_v[m][0]; mi = s_i[m][1]; mv = s_v[m][1];
    fl = ev && (e[6:0] inside {7'h6F, 7'h67} || (e[6:0] == 7'h63 && taken(e[14:12], lt, eq)));
    if (m == 0) h = ev && e[6:0] == 7'h03 && writes_rd(e) && dep(x, v, e[11:7]);
    else h = (ev && writes_rd(e) && dep(x, v, e[11:7])) ||
             (mv && writes_rd(mi) && dep(x, v, mi[11:7]));
    return {h && !fl, fl};
  endfunction

  function automatic logic [1:0] fsel(input int m, input logic [4:0] src);
    if (m != 0 || !s_v[m][0]) return 2'd0;
    if (s_v[m][1] && writes_rd(s_i[m][1]) && s_i[m][1][11:7] == src) return 2'd1;
    if (s_v[m][2] && writes_rd(s_i[m][2]) && s_i[m][2][11:7] == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] exp_vec(input int m, input logic [31:0] x, input logic v,
                                          input logic lt, input logic eq);
    logic [31:0] e, mi, w;
    logic ev, mv, wv;
    logic [1:0] sf;
    e = s_i[m][0]; mi = s_i[m][1]; w = s_i[m][2];
    ev = s_v[m][0]; mv = s_v[m][1]; wv = s_v[m][2];
    sf = hz(m, x, v, lt, eq);
    return {6'd0, sf[1], sf[0], sf[0], v && !legal(x),
            ev && e[6:0] == 7'h63 && e[13], ev ? opa_of(e) : 2'd0,
            ev && e[6:0] != 7'h33, ev ? alu_of(e) : 4'd0,
            fsel(m, e[19:15]), fsel(m, e[24:20]),
            mv && mi[6:0] == 7'h23, wv && writes_rd(w),
            wv ? wbsel_of(w) : 2'd0, wv ? w[11:7] : 5'd0, wv};
  endfunction

  function automatic logic [31:0] act_vec(input int k);
    return {6'd0, stall[k], flush[k], pc_sel[k], illegal[k], br_un[k], opa[k], opb[k], alu[k],
            fa[k], fb[k], memw[k], wbw[k], wbsel[k], wbrd[k], wbv[k]};
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) begin s_i[m][k] = '0; s_v[m][k] = 1'b0; end
      mcnt[m] = '0;
    end
  endtask

  task automatic model_advance();
    for (int m = 0; m < 2; m++) begin
      logic [1:0] sf;
      sf = hz(m, instr, id_vld, br_less, br_equal);
      mcnt[m] = mcnt[m] + 32'(s_v[m][1]);
      s_i[m][2] = s_i[m][1]; s_v[m][2] = s_v[m][1];
      s_i[m][1] = s_i[m][0]; s_v[m][1] = s_v[m][0];
      s_i[m][0] = instr;
      s_v[m][0] = id_vld && legal(instr) && sf == 2'b00;
    end
  endtask

  task automatic check_all();
    chk("ctl_fwd",   act_vec(0), exp_vec(0, instr, id_vld, br_less, br_equal));
    chk("ctl_nofwd", act_vec(1), exp_vec(1, instr, id_vld, br_less, br_equal));
    chk("ctl_cnt4",  act_vec(2), exp_vec(0, instr, id_vld, br_less, br_equal));
    chk("cnt_fwd",   cnt_a, mcnt[0]);
    chk("cnt_nofwd", cnt_b, mcnt[1]);
    chk("cnt_4bit",  {28'd0, cnt_c}, mcnt[0] & 32'hF);
  endtask

  // One cycle: drive ID inputs after the falling edge, compare, then advance the model.
  task automatic step(input logic [31:0] x, input logic v, input logic lt, input logic eq);
    @(negedge clk);
    instr = x; id_vld = v; br_less = lt; br_equal = eq;
    #1;
    check_all();
    model_advance();
  endtask

  task automatic do_reset();
    instr = '0; id_vld = 1'b0; br_less = 1'b0; br_equal = 1'b0;
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) step(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        ill;
    logic [3:0]  alu;
    logic [1:0]  opa;
    logic        opb;
    logic        brun;
  } vec_t;
  vec_t tbl [16];

  localparam logic [31:0] ADDI_X1 = 32'hFFF00093;
  localparam logic [31:0] ADD_X2  = 32'h00108133;
  localparam logic [31:0] LW_X1   = 32'h00012083;
  localparam logic [31:0] JAL_X0  = 32'h0080006F;

  initial begin
    logic [6:0] ops [11];
    int ns;
    tbl[0]  = '{32'hFFF00093, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};  // addi
    tbl[1]  = '{32'h4020D193, 1'b0, 4'b1101, 2'd0, 1'b1, 1'b0};  // srai
    tbl[2]  = '{32'h00108133, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};  // add
    tbl[3]  = '{32'h40108133, 1'b0, 4'b1000, 2'd0, 1'b0, 1'b0};  // sub
    tbl[4]  = '{32'h40008093, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};  // addi, imm bit30 set
    tbl[5]  = '{32'h0020B1B3, 1'b0, 4'b0011, 2'd0, 1'b0, 1'b0};  // sltu
    tbl[6]  = '{32'h00012083, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};  // lw
    tbl[7]  = '{32'h00112023, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};  // sw
    tbl[8]  = '{32'h00000463, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0};  // beq
    tbl[9]  = '{32'h0020E463, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1};  // bltu
    tbl[10] = '{32'h123452B7, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0};  // lui
    tbl[11] = '{32'h00000297, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0};  // auipc
    tbl[12] = '{32'h0080006F, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0};  // jal
    tbl[13] = '{32'h000100E7, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};  // jalr
    tbl[14] = '{32'h000000FF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};  // opcode 7F
    tbl[15] = '{32'h0000000B, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};  // custom-0

    do_reset();
    chk("rst_cnt", cnt_a, 32'd0);
    chk("rst_wbv", {31'd0, wbv[0]}, 32'd0);

    // Decode table: ID-time illegal flag, then EX control one cycle later.
    foreach (tbl[i]) begin
      step(tbl[i].ins, 1'b1, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_ill", i), {31'd0, illegal[0]}, {31'd0, tbl[i].ill});
      step(32'h0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_ex", i), {24'd0, br_un[0], opa[0], opb[0], alu[0]},
          {24'd0, tbl[i].brun, tbl[i].opa, tbl[i].opb, tbl[i].alu});
    end

    // addi x1 then add x2,x1,x1: forwarded from MEM, retire three cycles later.
    do_reset();
    step(ADDI_X1, 1'b1, 1'b0, 1'b0);
    step(ADD_X2, 1'b1, 1'b0, 1'b0);
    chk("raw_fwd_nostall", {31'd0, stall[0]}, 32'd0);
    step(32'h0, 1'b0, 1'b0, 1'b0);
    chk("raw_fwd_sel", {28'd0, fa[0], fb[0]}, 32'b0101);
    step(32'h0, 1'b0, 1'b0, 1'b0);
    chk("addi_wb", {25'd0, wbw[0], wbrd[0], wbv[0]}, {25'd0, 1'b1, 5'd1, 1'b1});
    chk("addi_cnt", cnt_a, 32'd1);

    // Load-use with forwarding: one stall, EX bubble, then WB forwarding.
    drain();
    step(LW_X1, 1'b1, 1'b0, 1'b0);
    step(ADD_X2, 1'b1, 1'b0, 1'b0);
    chk("lu_stall1", {31'd0, stall[0]}, 32'd1);
    step(ADD_X2, 1'b1, 1'b0, 1'b0);
    chk("lu_stall2", {31'd0, stall[0]}, 32'd0);
    chk("lu_bubble", {25'd0, opa[0], opb[0], alu[0]}, 32'd0);
    step(32'h0, 1'b0, 1'b0, 1'b0);
    chk("lu_fwd_sel", {28'd0, fa[0], fb[0]}, 32'b1010);

    // Load-use without forwarding: add held until the unit releases it.
    drain();
    step(LW_X1, 1'b1, 1'b0, 1'b0);
    ns = 0;
    for (int j = 0; j < 5; j++) begin
      step(ADD_X2, 1'b1, 1'b0, 1'b0);
      if (stall[1]) ns++;
      else break;
    end
    chk("nofwd_lu_stalls", ns, 32'd2);

    // Taken beq flushes once and leaves an EX bubble; bne with equal is not taken.
    drain();
    step(32'h00000463, 1'b1, 1'b0, 1'b1);
    step(ADDI_X1, 1'b1, 1'b0, 1'b1);
    chk("beq_redirect", {30'd0, pc_sel[0], flush[0]}, 32'b11);
    step(32'h0, 1'b0, 1'b0, 1'b1);
    chk("beq_after", {24'd0, pc_sel[0], opa[0], opb[0], alu[0]}, 32'd0);
    step(32'h00001463, 1'b1, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1);
    chk("bne_not_taken", {31'd0, pc_sel[0]}, 32'd0);

    // Jump in EX with a RAW hazard against MEM (no forwarding): flush wins.
    drain();
    step(LW_X1, 1'b1, 1'b0, 1'b0);
    step(JAL_X0, 1'b1, 1'b0, 1'b0);
    step(ADD_X2, 1'b1, 1'b0, 1'b0);
    chk("flush_haz", {30'd0, stall[1], flush[1]}, 32'b01);

    // Illegal opcode never produces a WB write.
    drain();
    step(32'h000000FF, 1'b1, 1'b0, 1'b0);
    chk("illegal_flag", {31'd0, illegal[0]}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      step(32'h0, 1'b0, 1'b0, 1'b0);
      chk("illegal_no_wb", {30'd0, wbw[0], wbv[0]}, 32'd0);
    end

    // 17 retirements wrap the 4-bit counter to 1.
    do_reset();
    for (int j = 0; j < 17; j++) step(ADDI_X1, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) step(32'h0, 1'b0, 1'b0, 1'b0);
    chk("cnt4_wrap", {28'd0, cnt_c}, 32'd1);
    chk("cnt32_17", cnt_a, 32'd17);

    // Randomised traffic with small register numbers to provoke hazards.
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h00};
    for (int j = 0; j < 3000; j++) begin
      logic [31:0] r;
      int kd;
      r = $urandom;
      kd = $urandom_range(0, 10);
      r[6:0] = (kd == 10) ? 7'($urandom) : ops[kd];
      r[11:7] = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      step(r, $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-stream clears everything without waiting for an edge.
    for (int j = 0; j < 4; j++) step(ADDI_X1, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_wbv", {31'd0, wbv[0]}, 32'd1);
    id_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ctl", act_vec(0), 32'd0);
    chk("rst_async_cnt", cnt_a, 32'd0);
    chk("rst_async_cnt4", {28'd0, cnt_c}, 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step(ADDI_X1, 1'b1, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_unit_pipe.md
# ctrl_unit_pipe

Pipelined control and hazard unit for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It decodes the ID-stage instruction and carries the control word through the ID/EX, EX/MEM and MEM/WB registers. It detects load-use and RAW hazards, resolves branches and jumps in EX, and generates forwarding selects and a retired-instruction counter.

## Interface
- FWD_EN, 1: 1 = forwarding active, stall only on load-use; 0 = no forwarding, stall on any RAW.
- CNT_W, 32: width of retire counter.
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_instr  in  32  instruction held in IF/ID.
- i_id_vld  in  1  IF/ID holds a valid instruction.
- i_br_less  in  1  EX comparator less (signedness per o_ex_br_un).
- i_br_equal  in  1  EX comparator equal.
- o_stall  out  1  hold PC and IF/ID this cycle.
- o_flush  out  1  kill IF/ID contents (taken branch or jump in EX).
- o_pc_sel  out  1  0 = pc+4, 1 = EX ALU result.
- o_illegal  out  1  ID holds a valid instruction with an unknown opcode.
- o_ex_br_un  out  1  EX comparator unsigned.
- o_ex_opa_sel  out  2  00 = rs1, 01 = pc, 10 = zero.
- o_ex_opb_sel  out  1  0 = rs2, 1 = imm.
- o_ex_alu_op  out  4  ALU operation.
- o_fwd_a_sel, o_fwd_b_sel  out  2 each  00 = regfile, 01 = EX/MEM alu_data, 10 = MEM/WB write-back data.
- o_mem_wren  out  1  store enable (MEM stage).
- o_wb_rd_wren  out  1  regfile write (WB stage).
- o_wb_sel  out  2  00 = alu_data, 01 = ld_data, 10 = pc_four.
- o_wb_rd_addr  out  5  destination register (WB stage).
- o_wb_insn_vld  out  1  instruction retires this cycle.
- o_retire_cnt  out  CNT_W  count of retired instructions.

## Operation
- **Decode by opcode:**
  - R 0110011 and I-ALU 0010011: alu_op = {b30, funct3}. b30 = instr[30] for R, and for I only when funct3 = 101; otherwise b30 = 0.
  - Load 0000011: add, opb = imm, wb = 01.
  - Store 0100011: add, opb = imm, mem_wren, no rd write.
  - Branch 1100011: opa = pc, opb = imm, add, br_un = funct3[1], no rd write.
  - LUI 0110111: opa = zero, opb = imm, add.
  - AUIPC 0010111: opa = pc, opb = imm, add.
  - JAL 1101111: opa = pc, wb = 10.
  - JALR 1100111: opa = rs1, wb = 10.
- A control word with rd = x0 has rd_wren forced to 0.
- Unknown opcode or i_id_vld = 0: the control word is a bubble (vld, rd_wren, mem_wren, branch and jump flags all 0).
- **Register uses:** rs1 for R, I-ALU, load, store, branch and JALR; rs2 for R, store and branch.
- **Branch taken (EX)**, by funct3: 000 eq, 001 !eq, 100/110 less, 101/111 !less. Other funct3 values are never taken.
- o_pc_sel = EX vld & (jump | branch taken). o_flush = o_pc_sel.
- **Load-use:** EX is a load with rd_wren, and the ID instruction uses its rd.
- **FWD_EN = 0 hazard:** any used ID source equals the rd of a rd_wren instruction in EX or MEM. The regfile is write-through, so WB never causes a stall.
- **o_stall** = hazard & ~o_flush.
  - On stall, ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  - On flush, ID/EX loads a bubble regardless of stall.
- **Forwarding (FWD_EN = 1)**, per EX source:
  - 01 if MEM rd_wren & rd == src.
  - Else 10 if WB rd_wren & rd == src.
  - Else 00.
- With FWD_EN = 0 both forwarding selects are tied to 00.
- **Retire counter:** o_retire_cnt increments when o_wb_insn_vld = 1 and wraps modulo 2^CNT_W.

## Timing
- Reset asynchronously clears all stage registers to bubbles and o_retire_cnt to 0. Every registered output is 0; o_stall, o_flush and o_pc_sel are 0.
- Decode, hazard and o_illegal are combinational from i_instr.
- EX outputs are registered; o_pc_sel is combinational from EX registers and i_br_*.
- An instruction reaches EX 1 cycle after leaving ID, MEM 2 cycles after, and WB 3 cycles after.
- Load-use penalty: 1 cycle.
- Taken branch or jump penalty: 2 cycles (IF/ID killed externally, ID killed here).
- Reset asserted mid-operation discards all in-flight instructions. No output glitch beyond the async clear.

## Test plan
- Reset, then addi x1,x0,-1 (0xFFF00093) → o_ex_alu_op = 0000, opb_sel = 1. Three cycles later o_wb_rd_wren = 1, o_wb_rd_addr = 1, o_retire_cnt = 1.
- srai x3,x1,2 (0x4020D193) → o_ex_alu_op = 1101. add x2,x1,x1 (0x00108133) issued right after addi x1 → o_fwd_a_sel = o_fwd_b_sel = 01, no stall.
- lw x1,0(x2) (0x00012083) then add x2,x1,x1 → o_stall = 1 for exactly 1 cycle and an EX bubble. The add's fwd selects = 10. With FWD_EN = 0 → 2 stall cycles.
- beq x0,x0,8 (0x00000463) with i_br_equal = 1 → o_pc_sel = o_flush = 1 for 1 cycle, and the next EX slot is a bubble. bne (0x00001463) with i_br_equal = 1 → o_pc_sel = 0.
- Flush coinciding with a load-use hazard → o_stall = 0, o_flush = 1. Opcode 0x7F with i_id_vld = 1 → o_illegal = 1 and no write ever reaches WB.
- CNT_W = 4 with 17 retirements → o_retire_cnt = 1. Reset asserted mid-stream → all outputs 0 immediately.
